// File: rtl/al_accel_acc_ctrl_if.sv
// al_accel_acc_ctrl_if
//   Output-beat stream from the accumulation-matrix sequencer to the output
//   buffer writeback path. One beat carries one requantized channel result.
//
//   out_data   signed 8-bit requantized result
//   out_ch     channel index of the beat (0..2)
//   out_valid  beat valid
//   out_last   marks the channel-2 beat, the last of a pixel
//   out_ready  downstream accept
//
//   master: the sequencer (drives data/ch/valid/last, receives ready)
//   slave : the output buffer (receives data/ch/valid/last, drives ready)
interface al_accel_acc_ctrl_if;
  logic signed [7:0] out_data;
  logic [1:0]        out_ch;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/al_accel_acc_ctrl.sv
// al_accel_acc_ctrl
//   Sequencer and drain for the accumulation matrix, handling one output pixel
//   per start. It optionally loads a new bias, writes the bias into the
//   accumulator, runs num_groups partial-sum accumulations, lets the last sum
//   settle, then requantizes the three 32-bit channel sums (arithmetic shift,
//   optional ReLU, int8 saturation) and streams them out as three beats.
//
//   clk, resetn           clock; synchronous active-low reset
//   enb                   global enable; low freezes state, gates strobes
//   start                 begin one pixel (honoured only in IDLE)
//   load_bias, num_groups,
//   shift, relu_en        pixel configuration, sampled with an accepted start
//   psum_valid/psum_ready partial-product handshake from the multiplier array
//   acc_bps_load          accumulator bias-load strobe
//   acc_bps_write         accumulator bias-write strobe
//   acc_inter_sum_write   accumulator accumulate strobe
//   acc_do_0..2           accumulator channel sums
//   out_if                output beat stream (master side)
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse after the last beat is accepted
module al_accel_acc_ctrl (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enb,
  input  logic               start,
  input  logic               load_bias,
  input  logic [7:0]         num_groups,
  input  logic [4:0]         shift,
  input  logic               relu_en,
  input  logic               psum_valid,
  output logic               psum_ready,
  output logic               acc_bps_load,
  output logic               acc_bps_write,
  output logic               acc_inter_sum_write,
  input  logic signed [31:0] acc_do_0,
  input  logic signed [31:0] acc_do_1,
  input  logic signed [31:0] acc_do_2,
  al_accel_acc_ctrl_if.master out_if,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_BIAS,
    WRITE_BIAS,
    ACCUM,
    SETTLE,
    DRAIN
  } state_t;

  state_t            state;
  logic [7:0]        grp_cnt;
  logic [7:0]        cfg_groups;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic signed [7:0] res_1;
  logic signed [7:0] res_2;

  // Shift, optional ReLU, then clamp to the int8 range.
  function automatic logic signed [7:0] requant(
    input logic signed [31:0] v,
    input logic [4:0]         sh,
    input logic               relu
  );
    logic signed [31:0] y;
    y = v >>> sh;
    if (relu && (y < 32'sd0)) y = 32'sd0;
    if (y > 32'sd127) return 8'sd127;
    if (y < -32'sd128) return -8'sd128;
    return y[7:0];
  endfunction

  // Accumulator strobes are decoded from the state so the accumulate strobe
  // can follow psum_valid in the same cycle as the data. Because bias-write
  // and accumulate live in different states they can never overlap.
  assign psum_ready          = enb && (state == ACCUM);
  assign acc_inter_sum_write = psum_ready && psum_valid;
  assign acc_bps_load        = enb && (state == LOAD_BIAS);
  assign acc_bps_write       = enb && (state == WRITE_BIAS);
  assign busy                = (state != IDLE);

  // Pixel sequencer. The beat index lives in out_ch itself; channel 0 goes
  // straight to out_data at capture time, so only channels 1 and 2 need
  // holding registers. done is cleared every cycle, even with enb low, so it
  // can never stretch beyond one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      grp_cnt           <= 8'd0;
      cfg_groups        <= 8'd0;
      cfg_shift         <= 5'd0;
      cfg_relu          <= 1'b0;
      res_1             <= 8'sd0;
      res_2             <= 8'sd0;
      out_if.out_data   <= 8'sd0;
      out_if.out_ch     <= 2'd0;
      out_if.out_valid  <= 1'b0;
      out_if.out_last   <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      if (enb) begin
        case (state)
          IDLE: begin
            if (start) begin
              cfg_groups <= num_groups;
              cfg_shift  <= shift;
              cfg_relu   <= relu_en;
              state      <= load_bias ? LOAD_BIAS : WRITE_BIAS;
            end
          end
          LOAD_BIAS: state <= WRITE_BIAS;
          WRITE_BIAS: begin
            grp_cnt <= 8'd0;
            state   <= (cfg_groups == 8'd0) ? SETTLE : ACCUM;
          end
          ACCUM: begin
            if (psum_valid) begin
              if (grp_cnt == cfg_groups - 8'd1) state <= SETTLE;
              else grp_cnt <= grp_cnt + 8'd1;
            end
          end
          SETTLE: begin
            out_if.out_data  <= requant(acc_do_0, cfg_shift, cfg_relu);
            res_1            <= requant(acc_do_1, cfg_shift, cfg_relu);
            res_2            <= requant(acc_do_2, cfg_shift, cfg_relu);
            out_if.out_ch    <= 2'd0;
            out_if.out_valid <= 1'b1;
            out_if.out_last  <= 1'b0;
            state            <= DRAIN;
          end
          DRAIN: begin
            if (out_if.out_ready) begin
              case (out_if.out_ch)
                2'd0: begin
                  out_if.out_data <= res_1;
                  out_if.out_ch   <= 2'd1;
                end
                2'd1: begin
                  out_if.out_data <= res_2;
                  out_if.out_ch   <= 2'd2;
                  out_if.out_last <= 1'b1;
                end
                default: begin
                  out_if.out_data  <= 8'sd0;
                  out_if.out_ch    <= 2'd0;
                  out_if.out_valid <= 1'b0;
                  out_if.out_last  <= 1'b0;
                  done             <= 1'b1;
                  state            <= IDLE;
                end
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_al_accel_acc_ctrl.sv
// tb_al_accel_acc_ctrl
//   Directed bench for al_accel_acc_ctrl. A small behavioural accumulator
//   model answers the bias-load / bias-write / accumulate strobes, and each
//   pixel run checks beats, done timing and strobe counts against
//   hand-computed values.
module tb_al_accel_acc_ctrl;

  logic               clk = 1'b0;
  logic               resetn;
  logic               enb;
  logic               start;
  logic               load_bias;
  logic [7:0]         num_groups;
  logic [4:0]         shift;
  logic               relu_en;
  logic               psum_valid;
  logic               psum_ready;
  logic               acc_bps_load;
  logic               acc_bps_write;
  logic               acc_inter_sum_write;
  logic signed [31:0] acc_q   [3];
  logic signed [31:0] bias_q  [3];
  logic signed [31:0] bias_in [3];
  logic signed [31:0] psum_in [3];
  logic               busy;
  logic               done;

  al_accel_acc_ctrl_if oif ();

  int checks = 0;
  int errors = 0;

  int n_load     = 0;
  int n_bwrite   = 0;
  int n_isw      = 0;
  int n_overlap  = 0;
  int n_off      = 0;
  int pidx       = 0;

  al_accel_acc_ctrl dut (
    .clk                 (clk),
    .resetn              (resetn),
    .enb                 (enb),
    .start               (start),
    .load_bias           (load_bias),
    .num_groups          (num_groups),
    .shift               (shift),
    .relu_en             (relu_en),
    .psum_valid          (psum_valid),
    .psum_ready          (psum_ready),
    .acc_bps_load        (acc_bps_load),
    .acc_bps_write       (acc_bps_write),
    .acc_inter_sum_write (acc_inter_sum_write),
    .acc_do_0            (acc_q[0]),
    .acc_do_1            (acc_q[1]),
    .acc_do_2            (acc_q[2]),
    .out_if              (oif),
    .busy                (busy),
    .done                (done)
  );

  always #5 clk = ~clk;

  // Accumulator model (accumulate has priority over bias-write) plus strobe
  // counters and the psum pattern cursor, which advances on every enabled
  // ACCUM cycle whether or not a partial product was offered.
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        acc_q[i]  <= 32'sd0;
        bias_q[i] <= 32'sd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (acc_bps_load) bias_q[i] <= bias_in[i];
        if (acc_inter_sum_write) acc_q[i] <= acc_q[i] + psum_in[i];
        else if (acc_bps_write) acc_q[i] <= bias_q[i];
      end
      if (psum_ready) pidx <= pidx + 1;
      if (acc_bps_load) n_load <= n_load + 1;
      if (acc_bps_write) n_bwrite <= n_bwrite + 1;
      if (acc_inter_sum_write) n_isw <= n_isw + 1;
      if (acc_bps_write && acc_inter_sum_write) n_overlap <= n_overlap + 1;
      if (!enb && (acc_bps_load || acc_bps_write || acc_inter_sum_write || psum_ready))
        n_off <= n_off + 1;
    end
  end

  task automatic checkOutput(input string name, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic setVec(input int b0, input int b1, input int b2,
                        input int p0, input int p1, input int p2);
    bias_in[0] = b0; bias_in[1] = b1; bias_in[2] = b2;
    psum_in[0] = p0; psum_in[1] = p1; psum_in[2] = p2;
  endtask

  // Runs one pixel. pat/plen give the psum_valid sequence over ACCUM cycles
  // (1 once exhausted); ready_stall holds out_ready low that many cycles on
  // beat 1, optionally pulsing start there; enb_stall_after drops enb for 4
  // cycles once that many accumulations are done (-1 = never).
  task automatic applyStimulus(input string tag, input bit lb, input int ng,
                               input int sh, input bit relu,
                               input bit [15:0] pat, input int plen,
                               input int ready_stall, input bit drain_start,
                               input int enb_stall_after,
                               input int e0, input int e1, input int e2,
                               input int exp_done_cyc, input int exp_loads,
                               input int exp_isw);
    int c, nb, k, done_seen, done_cnt, stall_left, rstall_left;
    int b_load, b_bw, b_isw, b_ov, b_off, pbase;
    bit stalled, rstall_done;
    int unsigned r;
    logic signed [31:0] expv [3];
    expv[0] = e0; expv[1] = e1; expv[2] = e2;

    @(negedge clk);
    b_load = n_load; b_bw = n_bwrite; b_isw = n_isw; b_ov = n_overlap;
    b_off = n_off; pbase = pidx;
    start = 1'b1; load_bias = lb; num_groups = ng[7:0]; shift = sh[4:0];
    relu_en = relu; enb = 1'b1; oif.out_ready = 1'b1; psum_valid = 1'b0;
    c = 0; nb = 0; done_seen = -1; done_cnt = 0; stall_left = 0;
    rstall_left = 0; stalled = 1'b0; rstall_done = 1'b0;

    while (c < 300) begin
      @(negedge clk);
      c++;
      r = $urandom;
      start = 1'b0; load_bias = r[0]; relu_en = r[1];
      shift = r[6:2]; num_groups = r[15:8];
      if (done === 1'b1) begin
        done_cnt++;
        if (done_seen < 0) done_seen = c;
      end
      if (done_seen >= 0 && c >= done_seen + 3) break;

      if (enb_stall_after >= 0 && !stalled && psum_ready === 1'b1 &&
          (n_isw - b_isw) == enb_stall_after) begin
        stalled = 1'b1;
        stall_left = 4;
      end
      enb = (stall_left == 0);
      if (stall_left == 3) begin
        checkOutput({tag, " psum_ready while disabled"}, 32'(psum_ready), 0);
        checkOutput({tag, " isw while disabled"}, 32'(acc_inter_sum_write), 0);
      end

      k = pidx - pbase;
      psum_valid = (k < plen) ? pat[k[3:0]] : 1'b1;

      if (oif.out_valid === 1'b1 && oif.out_ch === 2'd1 && ready_stall > 0 &&
          !rstall_done) begin
        rstall_left = ready_stall;
        rstall_done = 1'b1;
        if (drain_start) start = 1'b1;
      end
      if (rstall_left > 0) begin
        oif.out_ready = 1'b0;
        checkOutput({tag, " held data"}, 32'(oif.out_data), expv[1]);
        checkOutput({tag, " held ch"}, 32'(oif.out_ch), 1);
        rstall_left--;
      end else begin
        oif.out_ready = 1'b1;
      end

      if (oif.out_valid === 1'b1 && oif.out_ready && enb) begin
        if (nb < 3) begin
          checkOutput({tag, " beat data"}, 32'(oif.out_data), expv[nb]);
          checkOutput({tag, " beat ch"}, 32'(oif.out_ch), nb);
          checkOutput({tag, " beat last"}, 32'(oif.out_last), 32'(nb == 2));
        end
        nb++;
      end
      if (stall_left > 0) stall_left--;
    end

    enb = 1'b1; start = 1'b0; oif.out_ready = 1'b1;
    checkOutput({tag, " finished in budget"}, 32'(done_seen >= 0), 1);
    checkOutput({tag, " beats"}, nb, 3);
    checkOutput({tag, " done pulses"}, done_cnt, 1);
    checkOutput({tag, " idle after"}, 32'(busy), 0);
    if (exp_done_cyc >= 0) checkOutput({tag, " done cycle"}, done_seen, exp_done_cyc);
    checkOutput({tag, " bps_load count"}, n_load - b_load, exp_loads);
    checkOutput({tag, " bps_write count"}, n_bwrite - b_bw, 1);
    checkOutput({tag, " isw count"}, n_isw - b_isw, exp_isw);
    checkOutput({tag, " strobe overlap"}, n_overlap - b_ov, 0);
    checkOutput({tag, " strobe while disabled"}, n_off - b_off, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " out_data"}, 32'(oif.out_data), 0);
    checkOutput({tag, " out_ch"}, 32'(oif.out_ch), 0);
    checkOutput({tag, " out_valid"}, 32'(oif.out_valid), 0);
    checkOutput({tag, " out_last"}, 32'(oif.out_last), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " psum_ready"}, 32'(psum_ready), 0);
    checkOutput({tag, " strobes"},
                32'({acc_bps_load, acc_bps_write, acc_inter_sum_write}), 0);
  endtask

  initial begin
    int unsigned r;
    int cnt;
    setVec(0, 0, 0, 0, 0, 0);

    // Reset held for two cycles while every input toggles randomly.
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      enb = r[0]; start = r[1]; load_bias = r[2]; relu_en = r[3];
      psum_valid = r[4]; oif.out_ready = r[5]; shift = r[10:6];
      num_groups = r[18:11];
      @(negedge clk);
    end
    checkAllZero("reset");
    resetn = 1'b1; enb = 1'b1; start = 1'b0; psum_valid = 1'b0;
    oif.out_ready = 1'b1;
    $display("[TB] reset checked");

    // Bias only: LOAD(1) WRITE(2) SETTLE(3) beats 4..6, done at 7.
    setVec(100, -300, 5, 0, 0, 0);
    applyStimulus("bias_only", 1'b1, 0, 0, 1'b0, 16'h0000, 0, 0, 1'b0, -1,
                  100, -128, 5, 7, 1, 0);

    // Three accumulations of +10 on a zero bias, psum_valid 1,0,1,0,0,1.
    setVec(0, 0, 0, 10, 10, 10);
    applyStimulus("accum_gaps", 1'b1, 3, 0, 1'b0, 16'h0025, 6, 0, 1'b0, -1,
                  30, 30, 30, -1, 1, 3);

    // Requantize with shift 4: ReLU on, then bias reused with ReLU off.
    setVec(1000, -1000, 5000, 0, 0, 0);
    applyStimulus("requant_relu", 1'b1, 0, 4, 1'b1, 16'h0000, 0, 0, 1'b0, -1,
                  62, 0, 127, 7, 1, 0);
    setVec(0, 0, 0, 0, 0, 0);
    applyStimulus("requant_norelu", 1'b0, 0, 4, 1'b0, 16'h0000, 0, 0, 1'b0, -1,
                  62, -63, 127, 6, 0, 0);

    // Backpressure on beat 1 for 5 cycles, with a stray start in DRAIN.
    setVec(1, 2, 3, 1, 1, 1);
    applyStimulus("backpressure", 1'b1, 2, 0, 1'b0, 16'h0000, 0, 5, 1'b1, -1,
                  3, 4, 5, -1, 1, 2);

    // Same pixel with and without a 4-cycle enable stall mid-ACCUM.
    setVec(7, 7, 7, 3, -2, 20);
    applyStimulus("no_stall", 1'b1, 4, 0, 1'b0, 16'h0000, 0, 0, 1'b0, -1,
                  19, -1, 87, 11, 1, 4);
    applyStimulus("enb_stall", 1'b0, 4, 0, 1'b0, 16'h0000, 0, 0, 1'b0, 1,
                  19, -1, 87, -1, 0, 4);

    // Reset while a beat is being offered.
    setVec(9, 9, 9, 0, 0, 0);
    @(negedge clk);
    start = 1'b1; load_bias = 1'b1; num_groups = 8'd0; shift = 5'd0;
    relu_en = 1'b0; oif.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (oif.out_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("drain reached before reset", 32'(oif.out_valid), 1);
    resetn = 1'b0;
    @(negedge clk);
    checkAllZero("reset_in_drain");
    resetn = 1'b1; oif.out_ready = 1'b1;

    // Fresh pixel after the abort: (-5,300,64)+4, >>>1, ReLU -> 0,127,34.
    setVec(-5, 300, 64, 4, 4, 4);
    applyStimulus("after_reset", 1'b1, 1, 1, 1'b1, 16'h0000, 0, 0, 1'b0, -1,
                  0, 127, 34, 8, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
